alu_rsv_station: RTL and testbench

//   Reservation station in front of the two-cycle ALU functional unit in the
//   out-of-order core. It holds issued ALU ops until both source operands are

---
 rtl/alu_rsv_station.sv | 156 +++++++++++++++
 tb/tb_alu_rsv_station.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rsv_station.sv
// rtl/alu_rsv_station.sv - ALU reservation station with CDB snooping and cooldown-paced dispatch
module alu_rsv_station #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 3,
   parameter int XLEN  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [3:0]       issue_ctrl,
   input  logic [TAG_W-1:0] issue_dtag,
   input  logic [TAG_W-1:0] issue_qj,
   input  logic [XLEN-1:0]  issue_vj,
   input  logic [TAG_W-1:0] issue_qk,
   input  logic [XLEN-1:0]  issue_vk,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]  cdb_data,
   output logic             disp_en,
   output logic [3:0]       disp_ctrl,
   output logic [XLEN-1:0]  disp_a,
   output logic [XLEN-1:0]  disp_b,
   output logic [TAG_W-1:0] disp_tag
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // COOL covers the FU compute cycle following every dispatch
   typedef enum logic {
      IDLE = 1'b0,
      COOL = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [DEPTH-1:0] busy;
   logic [3:0]       ctrl [DEPTH];
   logic [TAG_W-1:0] dtag [DEPTH];
   logic [TAG_W-1:0] qj   [DEPTH];
   logic [XLEN-1:0]  vj   [DEPTH];
   logic [TAG_W-1:0] qk   [DEPTH];
   logic [XLEN-1:0]  vk   [DEPTH];

   logic [IW-1:0] free_idx;
   logic [IW-1:0] rdy_idx;
   logic          rdy_any;
   logic          issue_fire;
   logic          disp_fire;
   logic          byp_j;
   logic          byp_k;

   // Freeing by dispatch only becomes visible next cycle because busy is registered
   assign issue_ready = |(~busy);
   assign issue_fire  = issue_valid && issue_ready;

   // An operand whose producer broadcasts in the issue cycle is captured directly
   assign byp_j = cdb_valid && (issue_qj != '0) && (issue_qj == cdb_tag);
   assign byp_k = cdb_valid && (issue_qk != '0) && (issue_qk == cdb_tag);

   // Priority pick of the lowest free entry and the lowest ready entry
   always_comb begin
      free_idx = '0;
      rdy_idx  = '0;
      rdy_any  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!busy[i]) begin
            free_idx = IW'(i);
         end
         if (busy[i] && (qj[i] == '0) && (qk[i] == '0)) begin
            rdy_idx = IW'(i);
            rdy_any = 1'b1;
         end
      end
   end

   // Dispatch decision and cooldown next-state
   always_comb begin
      state_d   = state_q;
      disp_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (rdy_any) begin
               disp_fire = 1'b1;
               state_d   = COOL;
            end
         end
         COOL: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Cooldown state register; a flush abandons any pending cooldown
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Registered dispatch port; payload holds between pulses and survives flush
   always_ff @(posedge clk) begin
      if (rst) begin
         disp_en   <= 1'b0;
         disp_ctrl <= '0;
         disp_a    <= '0;
         disp_b    <= '0;
         disp_tag  <= '0;
      end else if (flush) begin
         disp_en <= 1'b0;
      end else begin
         disp_en <= disp_fire;
         if (disp_fire) begin
            disp_ctrl <= ctrl[rdy_idx];
            disp_a    <= vj[rdy_idx];
            disp_b    <= vk[rdy_idx];
            disp_tag  <= dtag[rdy_idx];
         end
      end
   end

   // Entry update: CDB capture, dispatch release and issue write act on disjoint entries
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         busy <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && cdb_valid) begin
               if ((qj[i] != '0) && (qj[i] == cdb_tag)) begin
                  vj[i] <= cdb_data;
                  qj[i] <= '0;
               end
               if ((qk[i] != '0) && (qk[i] == cdb_tag)) begin
                  vk[i] <= cdb_data;
                  qk[i] <= '0;
               end
            end
            if (disp_fire && (rdy_idx == IW'(i))) begin
               busy[i] <= 1'b0;
            end
            if (issue_fire && (free_idx == IW'(i))) begin
               busy[i] <= 1'b1;
               ctrl[i] <= issue_ctrl;
               dtag[i] <= issue_dtag;
               qj[i]   <= byp_j ? '0 : issue_qj;
               vj[i]   <= byp_j ? cdb_data : issue_vj;
               qk[i]   <= byp_k ? '0 : issue_qk;
               vk[i]   <= byp_k ? cdb_data : issue_vk;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_rsv_station.sv
// tb/tb_alu_rsv_station.sv - self-checking bench for alu_rsv_station against a behavioural model
module tb_alu_rsv_station;

   localparam int DEPTH = 4;
   localparam int TAG_W = 3;
   localparam int XLEN  = 32;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             flush = 1'b0;
   logic             issue_valid = 1'b0;
   logic             issue_ready;
   logic [3:0]       issue_ctrl = '0;
   logic [TAG_W-1:0] issue_dtag = '0;
   logic [TAG_W-1:0] issue_qj = '0;
   logic [XLEN-1:0]  issue_vj = '0;
   logic [TAG_W-1:0] issue_qk = '0;
   logic [XLEN-1:0]  issue_vk = '0;
   logic             cdb_valid = 1'b0;
   logic [TAG_W-1:0] cdb_tag = '0;
   logic [XLEN-1:0]  cdb_data = '0;
   logic             disp_en;
   logic [3:0]       disp_ctrl;
   logic [XLEN-1:0]  disp_a;
   logic [XLEN-1:0]  disp_b;
   logic [TAG_W-1:0] disp_tag;

   alu_rsv_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_ctrl(issue_ctrl), .issue_dtag(issue_dtag),
      .issue_qj(issue_qj), .issue_vj(issue_vj),
      .issue_qk(issue_qk), .issue_vk(issue_vk),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .disp_en(disp_en), .disp_ctrl(disp_ctrl), .disp_a(disp_a),
      .disp_b(disp_b), .disp_tag(disp_tag)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Behavioural model: a table of waiting ops plus the last dispatch port values
   bit               m_valid = 0;
   bit               m_busy [DEPTH];
   logic [3:0]       m_ctrl [DEPTH];
   logic [TAG_W-1:0] m_dtag [DEPTH];
   logic [TAG_W-1:0] m_qj   [DEPTH];
   logic [XLEN-1:0]  m_vj   [DEPTH];
   logic [TAG_W-1:0] m_qk   [DEPTH];
   logic [XLEN-1:0]  m_vk   [DEPTH];
   bit               m_en = 0;
   logic [3:0]       m_octrl = '0;
   logic [XLEN-1:0]  m_oa = '0;
   logic [XLEN-1:0]  m_ob = '0;
   logic [TAG_W-1:0] m_otag = '0;

   function automatic bit m_has_free();
      for (int i = 0; i < DEPTH; i++) if (!m_busy[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_update();
      int fi = -1;
      int ri = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (!m_busy[i] && fi < 0) fi = i;
         if (m_busy[i] && m_qj[i] == 0 && m_qk[i] == 0 && ri < 0) ri = i;
      end
      if (rst) begin
         m_valid = 1;
         for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
         m_en = 0; m_octrl = '0; m_oa = '0; m_ob = '0; m_otag = '0;
         return;
      end
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) m_busy[i] = 0;
         m_en = 0;
         return;
      end
      // a pulse last cycle means the FU is computing, so no dispatch now
      if (!m_en && ri >= 0) begin
         m_en = 1;
         m_octrl = m_ctrl[ri]; m_oa = m_vj[ri]; m_ob = m_vk[ri]; m_otag = m_dtag[ri];
         m_busy[ri] = 0;
      end else begin
         m_en = 0;
      end
      if (cdb_valid) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (m_busy[i] && m_qj[i] == cdb_tag) begin m_vj[i] = cdb_data; m_qj[i] = 0; end
            if (m_busy[i] && m_qk[i] == cdb_tag) begin m_vk[i] = cdb_data; m_qk[i] = 0; end
         end
      end
      if (issue_valid && fi >= 0) begin
         m_busy[fi] = 1;
         m_ctrl[fi] = issue_ctrl;
         m_dtag[fi] = issue_dtag;
         if (cdb_valid && issue_qj == cdb_tag) begin m_qj[fi] = 0; m_vj[fi] = cdb_data; end
         else begin m_qj[fi] = issue_qj; m_vj[fi] = issue_vj; end
         if (cdb_valid && issue_qk == cdb_tag) begin m_qk[fi] = 0; m_vk[fi] = cdb_data; end
         else begin m_qk[fi] = issue_qk; m_vk[fi] = issue_vk; end
      end
   endtask

   int               n_pulse = 0;
   int               pulse_cyc [$];
   logic [TAG_W-1:0] pulse_tag [$];
   logic [XLEN-1:0]  pulse_a [$];
   logic [XLEN-1:0]  pulse_b [$];

   task automatic clr_log();
      n_pulse = 0;
      pulse_cyc.delete(); pulse_tag.delete(); pulse_a.delete(); pulse_b.delete();
   endtask

   task automatic step();
      if (m_valid) check("issue_ready", 32'(issue_ready), 32'(m_has_free()));
      model_update();
      @(posedge clk);
      #1;
      cyc++;
      if (m_valid) begin
         check("disp_en", 32'(disp_en), 32'(m_en));
         check("disp_ctrl", 32'(disp_ctrl), 32'(m_octrl));
         check("disp_a", disp_a, m_oa);
         check("disp_b", disp_b, m_ob);
         check("disp_tag", 32'(disp_tag), 32'(m_otag));
      end
      if (disp_en === 1'b1) begin
         n_pulse++;
         pulse_cyc.push_back(cyc);
         pulse_tag.push_back(disp_tag);
         pulse_a.push_back(disp_a);
         pulse_b.push_back(disp_b);
      end
   endtask

   task automatic idle();
      rst = 0; flush = 0; issue_valid = 0; cdb_valid = 0;
   endtask

   task automatic put(input logic [3:0] c, input logic [TAG_W-1:0] d,
                      input logic [TAG_W-1:0] j, input logic [XLEN-1:0] a,
                      input logic [TAG_W-1:0] k, input logic [XLEN-1:0] b);
      issue_valid = 1; issue_ctrl = c; issue_dtag = d;
      issue_qj = j; issue_vj = a; issue_qk = k; issue_vk = b;
   endtask

   task automatic idle_steps(input int n);
      idle();
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #1;
      // reset
      rst = 1;
      step(); step();
      idle();
      check("rst_ready", 32'(issue_ready), 32'd1);
      check("rst_en", 32'(disp_en), 32'd0);
      check("rst_a", disp_a, 32'd0);
      check("rst_tag", 32'(disp_tag), 32'd0);

      // single ready op
      clr_log();
      put(4'b0001, 3'd1, 3'd0, 32'd5, 3'd0, 32'd7);
      step();
      idle_steps(5);
      check("t2_pulses", n_pulse, 1);
      if (n_pulse == 1) begin
         check("t2_a", pulse_a[0], 32'd5);
         check("t2_b", pulse_b[0], 32'd7);
         check("t2_tag", 32'(pulse_tag[0]), 32'd1);
         check("t2_ctrl", 32'(disp_ctrl), 32'b0001);
      end

      // fill with ops waiting on tag 3, then broadcast
      clr_log();
      for (int i = 0; i < DEPTH; i++) begin
         put(4'(i + 2), 3'(i + 4), 3'd3, 32'hFFFF, 3'd0, 32'(i));
         step();
      end
      idle();
      check("t3_full", 32'(issue_ready), 32'd0);
      cdb_valid = 1; cdb_tag = 3'd3; cdb_data = 32'h10;
      step();
      idle_steps(10);
      check("t3_pulses", n_pulse, DEPTH);
      for (int i = 0; i < pulse_tag.size(); i++) begin
         check("t3_order", 32'(pulse_tag[i]), 32'(i + 4));
         check("t3_a", pulse_a[i], 32'h10);
         if (i > 0) check("t3_gap", pulse_cyc[i] - pulse_cyc[i-1], 2);
      end
      check("t3_ready", 32'(issue_ready), 32'd1);

      // issue-cycle bypass
      clr_log();
      put(4'd3, 3'd2, 3'd2, 32'hDEAD, 3'd0, 32'd9);
      cdb_valid = 1; cdb_tag = 3'd2; cdb_data = 32'hAB;
      step();
      idle_steps(5);
      check("t4_pulses", n_pulse, 1);
      if (n_pulse == 1) begin
         check("t4_a", pulse_a[0], 32'hAB);
         check("t4_b", pulse_b[0], 32'd9);
      end

      // back-to-back ready ops are spaced by the cooldown
      clr_log();
      put(4'd4, 3'd5, 3'd0, 32'd1, 3'd0, 32'd2);
      step();
      put(4'd5, 3'd6, 3'd0, 32'd3, 3'd0, 32'd4);
      step();
      idle_steps(5);
      check("t5_pulses", n_pulse, 2);
      if (n_pulse == 2) check("t5_gap", pulse_cyc[1] - pulse_cyc[0], 2);

      // flush with a simultaneous CDB hit and issue
      clr_log();
      for (int i = 0; i < 3; i++) begin
         put(4'd6, 3'(i + 1), 3'd5, 32'd0, 3'd0, 32'd1);
         step();
      end
      idle();
      flush = 1; cdb_valid = 1; cdb_tag = 3'd5; cdb_data = 32'h55;
      put(4'd7, 3'd7, 3'd0, 32'd1, 3'd0, 32'd1);
      step();
      idle();
      check("t6_ready", 32'(issue_ready), 32'd1);
      cdb_valid = 1; cdb_tag = 3'd5;
      step();
      idle_steps(6);
      check("t6_pulses", n_pulse, 0);

      // randomized traffic
      for (int n = 0; n < 2000; n++) begin
         idle();
         rst = (n == 1000);
         flush = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 1) == 1) begin
            put(4'($urandom), 3'($urandom),
                ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(1, 3)), $urandom,
                ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(1, 3)), $urandom);
         end
         if ($urandom_range(0, 4) < 2) begin
            cdb_valid = 1;
            cdb_tag = 3'($urandom_range(1, 3));
            cdb_data = $urandom;
         end
         step();
      end
      idle_steps(2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
